// File: rtl/rf_seq_pkg.sv
// Shared types for the register-file command sequencer.
package rf_seq_pkg;
  localparam int NUM_REGS = 4;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    OP_LDI = 2'b00,
    OP_MOV = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD_A = 2'b01,
    S_RD_B = 2'b10,
    S_WR   = 2'b11
  } state_e;
endpackage

// File: rtl/rf_seq_alu.sv
// Combinational mod-2^DATA_W result with carry/borrow and zero flags.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);
  logic [DATA_W:0] sum, diff;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    diff     = {1'b0, a_i} - {1'b0, b_i};
    result_o = imm_i;
    carry_o  = 1'b0;
    case (op_i)
      OP_LDI: result_o = imm_i;
      OP_MOV: result_o = a_i;
      OP_ADD: begin
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_SUB: begin
        // top bit of the 9-bit difference is the borrow (a < b)
        result_o = diff[DATA_W-1:0];
        carry_o  = diff[DATA_W];
      end
      default: ;
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/rf_op_sequencer.sv
// Sequences one register-transfer command at a time into register-file
// read/write strobes; every rf_* output is driven directly by a flop.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_dst,
  input  logic [IDX_W-1:0]  cmd_src_a,
  input  logic [IDX_W-1:0]  cmd_src_b,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rf_read_enable,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_r_address,
  output logic [ADDR_W-1:0] rf_w_address,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_zero
);
  state_e              state_q, state_d;
  op_e                 op_q;
  logic [IDX_W-1:0]    dst_q, src_b_q;
  logic [DATA_W-1:0]   imm_q, op_a_q, op_b_q;
  logic                rd_en_q, wr_en_q, wr_carry_q, wr_zero_q;
  logic [ADDR_W-1:0]   r_addr_q, w_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                res_valid_q, res_carry_q, res_zero_q;
  logic [DATA_W-1:0]   res_data_q;

  logic                idle, accept;
  op_e                 alu_op;
  logic [DATA_W-1:0]   alu_a, alu_b, alu_imm, alu_res;
  logic                alu_carry, alu_zero;

  assign idle   = (state_q == S_IDLE);
  assign accept = idle && cmd_valid;

  // The result is registered on the edge entering WR, so the operand being
  // read in that same cycle is taken straight from the read-data bus.
  assign alu_op  = idle ? op_e'(cmd_op) : op_q;
  assign alu_imm = idle ? cmd_imm : imm_q;
  assign alu_a   = (state_q == S_RD_A) ? rf_read_data : op_a_q;
  assign alu_b   = (state_q == S_RD_B) ? rf_read_data : op_b_q;

  rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i    (alu_op),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .imm_i   (alu_imm),
    .result_o(alu_res),
    .carry_o (alu_carry),
    .zero_o  (alu_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) state_d = (op_e'(cmd_op) == OP_LDI) ? S_WR : S_RD_A;
      S_RD_A: state_d = (op_q == OP_MOV) ? S_WR : S_RD_B;
      S_RD_B: state_d = S_WR;
      S_WR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LDI;
      dst_q       <= '0;
      src_b_q     <= '0;
      imm_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      r_addr_q    <= '0;
      w_addr_q    <= '0;
      wr_data_q   <= '0;
      wr_carry_q  <= 1'b0;
      wr_zero_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op_e'(cmd_op);
        dst_q   <= cmd_dst;
        src_b_q <= cmd_src_b;
        imm_q   <= cmd_imm;
      end
      if (state_q == S_RD_A) op_a_q <= rf_read_data;
      if (state_q == S_RD_B) op_b_q <= rf_read_data;

      // Strobes decoded from next state so they leave flops already settled.
      rd_en_q <= (state_d == S_RD_A) || (state_d == S_RD_B);
      wr_en_q <= (state_d == S_WR);
      if (state_d == S_RD_A)      r_addr_q <= ADDR_W'(cmd_src_a);
      else if (state_d == S_RD_B) r_addr_q <= ADDR_W'(src_b_q);
      if (state_d == S_WR) begin
        w_addr_q   <= idle ? ADDR_W'(cmd_dst) : ADDR_W'(dst_q);
        wr_data_q  <= alu_res;
        wr_carry_q <= alu_carry;
        wr_zero_q  <= alu_zero;
      end

      res_valid_q <= (state_q == S_WR);
      if (state_q == S_WR) begin
        res_data_q  <= wr_data_q;
        res_carry_q <= wr_carry_q;
        res_zero_q  <= wr_zero_q;
      end
    end
  end

  assign cmd_ready       = idle;
  assign rf_read_enable  = rd_en_q;
  assign rf_write_enable = wr_en_q;
  assign rf_r_address    = r_addr_q;
  assign rf_w_address    = w_addr_q;
  assign rf_write_data   = wr_data_q;
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign res_carry       = res_carry_q;
  assign res_zero        = res_zero_q;
endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench: directed table, reset corner cases, then random commands against a
// register-array model of what each command should leave behind.
module tb_rf_op_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_dst, cmd_src_a, cmd_src_b;
  logic [7:0]  cmd_imm;
  logic        rf_read_enable, rf_write_enable;
  logic [31:0] rf_r_address, rf_w_address;
  logic [7:0]  rf_write_data, rf_read_data;
  logic        res_valid, res_carry, res_zero;
  logic [7:0]  res_data;

  always #5 clk = ~clk;

  rf_op_sequencer #(.ADDR_W(32), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
    .rf_read_enable(rf_read_enable), .rf_write_enable(rf_write_enable),
    .rf_r_address(rf_r_address), .rf_w_address(rf_w_address),
    .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
    .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero)
  );

  // Register file the sequencer drives
  logic [7:0] rf [4];
  always @(posedge clk) if (rf_write_enable) rf[rf_w_address[1:0]] <= rf_write_data;
  assign rf_read_data = rf_read_enable ? rf[rf_r_address[1:0]] : 8'h00;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register contents plus plain-arithmetic semantics.
  logic [7:0] mrf [4];
  task automatic model_exec(input logic [1:0] op, dst, sa, sb, input logic [7:0] imm,
                            output logic [7:0] d, output logic c);
    int a, b, r;
    a = int'(mrf[sa]); b = int'(mrf[sb]);
    c = 1'b0;
    case (op)
      2'd0: r = int'(imm);
      2'd1: r = a;
      2'd2: begin r = a + b; c = (r > 255); end
      default: begin r = a - b; c = (a < b); end
    endcase
    d = 8'(((r % 256) + 256) % 256);
    mrf[dst] = d;
  endtask

  task automatic run_cmd(input logic [1:0] op, dst, sa, sb, input logic [7:0] imm,
                         input logic [7:0] ed, input logic ec, ez);
    int lat, n, wcyc, rcyc, rdy_low, rd_cnt;
    logic [31:0] ra1, ra2, wa;
    logic [7:0] wd, rd;
    logic rc, rz;
    bit done;
    lat = (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 3;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_dst = 2'($urandom); cmd_src_a = 2'($urandom);
    cmd_src_b = 2'($urandom); cmd_imm = 8'($urandom);
    n = 1; wcyc = 0; rcyc = 0; rdy_low = 0; rd_cnt = 0;
    ra1 = '0; ra2 = '0; wa = '0; wd = '0; rd = '0; rc = 1'b0; rz = 1'b0; done = 1'b0;
    while (!done && n <= 8) begin
      chk("rd_wr_exclusive", {31'b0, rf_read_enable & rf_write_enable}, 0);
      if (rf_read_enable) begin
        if (rd_cnt == 0) ra1 = rf_r_address; else ra2 = rf_r_address;
        rd_cnt++;
      end
      if (rf_write_enable) begin wcyc = n; wa = rf_w_address; wd = rf_write_data; end
      if (!cmd_ready) rdy_low++;
      if (res_valid) begin
        done = 1'b1; rcyc = n; rd = res_data; rc = res_carry; rz = res_zero;
      end else begin
        @(posedge clk); @(negedge clk); n++;
      end
    end
    chk("write_cycle", wcyc, lat);
    chk("write_addr", wa, {30'b0, dst});
    chk("write_data", wd, ed);
    chk("res_valid_cycle", rcyc, lat + 1);
    chk("res_data", rd, ed);
    chk("res_carry", rc, ec);
    chk("res_zero", rz, ez);
    chk("ready_low_cycles", rdy_low, lat);
    chk("read_count", rd_cnt, lat - 1);
    if (op != 2'd0) chk("read_addr_a", ra1, {30'b0, sa});
    if (op[1])      chk("read_addr_b", ra2, {30'b0, sb});
    chk("rf_dst_value", rf[dst], ed);
  endtask

  typedef struct {
    logic [1:0] op, dst, sa, sb;
    logic [7:0] imm, ed;
    logic       ec, ez;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [7:0] md;
    logic       mc;
    int         cnt;
    vt[0]  = '{2'd0, 2'd2, 2'd0, 2'd0, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vt[1]  = '{2'd0, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0, 1'b0};
    vt[2]  = '{2'd0, 2'd1, 2'd0, 2'd0, 8'h20, 8'h20, 1'b0, 1'b0};
    vt[3]  = '{2'd0, 2'd3, 2'd0, 2'd0, 8'h5A, 8'h5A, 1'b0, 1'b0};
    vt[4]  = '{2'd2, 2'd3, 2'd0, 2'd1, 8'h00, 8'h10, 1'b1, 1'b0};
    vt[5]  = '{2'd0, 2'd1, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0};
    vt[6]  = '{2'd3, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[7]  = '{2'd0, 2'd2, 2'd0, 2'd0, 8'h03, 8'h03, 1'b0, 1'b0};
    vt[8]  = '{2'd0, 2'd3, 2'd0, 2'd0, 8'h07, 8'h07, 1'b0, 1'b0};
    vt[9]  = '{2'd3, 2'd0, 2'd2, 2'd3, 8'h00, 8'hFC, 1'b1, 1'b0};
    vt[10] = '{2'd1, 2'd0, 2'd3, 2'd0, 8'h00, 8'h07, 1'b0, 1'b0};
    vt[11] = '{2'd0, 2'd2, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[12] = '{2'd0, 2'd2, 2'd0, 2'd0, 8'h80, 8'h80, 1'b0, 1'b0};
    vt[13] = '{2'd2, 2'd2, 2'd2, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1};

    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_imm = '0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rd_en", rf_read_enable, 0);
    chk("rst_wr_en", rf_write_enable, 0);
    chk("rst_r_addr", rf_r_address, 0);
    chk("rst_w_addr", rf_w_address, 0);
    chk("rst_wdata", rf_write_data, 0);
    chk("rst_res", {res_valid, res_carry, res_zero, res_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table; consecutive entries are issued in the res_valid cycle.
    for (int i = 0; i < 14; i++) begin
      model_exec(vt[i].op, vt[i].dst, vt[i].sa, vt[i].sb, vt[i].imm, md, mc);
      run_cmd(vt[i].op, vt[i].dst, vt[i].sa, vt[i].sb, vt[i].imm, vt[i].ed, vt[i].ec, vt[i].ez);
    end

    // Reset during RD_B of an ADD: strobes drop at once, no result, dst intact
    model_exec(2'd0, 2'd3, 2'd0, 2'd0, 8'h33, md, mc);
    run_cmd(2'd0, 2'd3, 2'd0, 2'd0, 8'h33, 8'h33, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_dst = 2'd3; cmd_src_a = 2'd0; cmd_src_b = 2'd1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rstB_rd_en_before", rf_read_enable, 1);
    chk("rstB_rd_addr_before", rf_r_address, 1);
    rst = 1'b1;
    #1;
    chk("rstB_rd_en", rf_read_enable, 0);
    chk("rstB_wr_en", rf_write_enable, 0);
    chk("rstB_res_valid", res_valid, 0);
    chk("rstB_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (res_valid || rf_write_enable || !cmd_ready) cnt++;
    end
    chk("rstB_quiet_after", cnt, 0);
    chk("rstB_dst_kept", rf[3], 8'h33);

    // Reset inside the WR cycle cuts the write strobe before it lands
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dst = 2'd3; cmd_imm = 8'h77;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    chk("rstW_wr_en_before", rf_write_enable, 1);
    rst = 1'b1;
    #1;
    chk("rstW_wr_en", rf_write_enable, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rstW_no_result", res_valid, 0);
    chk("rstW_dst_kept", rf[3], 8'h33);

    // Random commands against the model, with occasional idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op, dst, sa, sb;
      logic [7:0] imm;
      op = 2'($urandom); dst = 2'($urandom); sa = 2'($urandom); sb = 2'($urandom);
      imm = 8'($urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      model_exec(op, dst, sa, sb, imm, md, mc);
      run_cmd(op, dst, sa, sb, imm, md, mc, (md == 8'h00));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
